// File: rtl/fp_mul_iter_if.sv
// ---------------------------------------------------------------------------
// fp_mul_iter_if
// Handshake bundle between the FPU dispatch and the iterative FP multiplier.
//   in_valid / in_ready  : operand handshake (dispatch -> multiplier)
//   a, b                 : operands {sign, exp[EXP_W], frac[MAN_W]}
//   rnd_mode             : 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
//   out_valid / out_ready: result handshake (multiplier -> consumer)
//   result               : product
//   flags                : {NV, OF, UF, NX}
// Modports: master = dispatch/consumer side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface fp_mul_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mul_iter.sv
// ---------------------------------------------------------------------------
// fp_mul_iter
// Parametrised IEEE-754 multiplier with an iterative shift-add significand
// multiplier (one multiplier bit per cycle), four rounding modes, DAZ on
// input subnormals and flush-to-zero on underflow.
// Ports:
//   CLK  : clock, rising edge
//   RSTn : asynchronous active-low reset
//   bus  : fp_mul_iter_if.slave (operand/result handshakes, result, flags)
// ---------------------------------------------------------------------------
module fp_mul_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          CLK,
    input  logic          RSTn,
    fp_mul_iter_if.slave  bus
);
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int SIG_W = MAN_W + 1;
    localparam int PW    = 2 * SIG_W;
    localparam int EW2   = EXP_W + 2;
    localparam int CNT_W = $clog2(SIG_W + 1);

    localparam logic [EW2-1:0]   BIAS_E   = EW2'((2 ** (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0]   EMAX_E   = EW2'((2 ** EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIG_W - 1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0]     MAG_INF  = {EXP_ONES, {MAN_W{1'b0}}};
    localparam logic [W-2:0]     MAG_MAX  = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;

    state_t           r_state, w_state_next;
    logic [W-1:0]     r_a, r_b, r_result;
    logic [1:0]       r_rnd;
    logic             r_sign, r_special, r_guard, r_sticky;
    logic [EW2-1:0]   r_exp;            // two's complement, two guard bits
    logic [PW-1:0]    r_mcand, r_acc;
    logic [SIG_W-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [MAN_W-1:0] r_frac;
    logic [3:0]       r_flags;

    // ---------------- operand decode ----------------
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_a_snan, w_b_snan, w_sign, w_special;
    logic [W-1:0]     w_spec_res;
    logic [3:0]       w_spec_fl;
    logic [EW2-1:0]   w_exp_sum;

    assign w_a_exp  = r_a[W-2 -: EXP_W];
    assign w_b_exp  = r_b[W-2 -: EXP_W];
    assign w_a_frac = r_a[MAN_W-1:0];
    assign w_b_frac = r_b[MAN_W-1:0];
    // Subnormal inputs decode as zero (exp==0 regardless of fraction).
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (w_a_exp == EXP_ONES) && (w_a_frac == '0);
    assign w_b_inf  = (w_b_exp == EXP_ONES) && (w_b_frac == '0);
    assign w_a_nan  = (w_a_exp == EXP_ONES) && (w_a_frac != '0);
    assign w_b_nan  = (w_b_exp == EXP_ONES) && (w_b_frac != '0);
    assign w_a_snan = w_a_nan && !w_a_frac[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_b_frac[MAN_W-1];
    assign w_sign   = r_a[W-1] ^ r_b[W-1];
    assign w_exp_sum = EW2'(w_a_exp) + EW2'(w_b_exp) - BIAS_E;

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = {w_sign, {(W-1){1'b0}}};
        w_spec_fl  = 4'b0000;
        if (w_a_nan || w_b_nan) begin
            w_spec_res = QNAN;
            w_spec_fl  = {w_a_snan || w_b_snan, 3'b000};
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_res = QNAN;
            w_spec_fl  = 4'b1000;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_res = {w_sign, MAG_INF};
        end else if (!(w_a_zero || w_b_zero)) begin
            w_special  = 1'b0;
        end
    end

    // ---------------- normalisation ----------------
    // Product is in [1,4): drop the leading one so the fraction, guard and
    // sticky positions are fixed whichever of the top two bits is set.
    logic [PW-2:0] w_p_norm;
    assign w_p_norm = r_acc[PW-1] ? r_acc[PW-2:0] : {r_acc[PW-3:0], 1'b0};

    // ---------------- rounding ----------------
    logic           w_inc, w_inexact, w_of, w_uf, w_to_inf;
    logic [MAN_W:0] w_frac_rnd;
    logic [EW2-1:0] w_exp_fin;
    logic [W-1:0]   w_rnd_res;
    logic [3:0]     w_rnd_fl;

    assign w_inexact = r_guard | r_sticky;

    always_comb begin
        w_inc = 1'b0;
        case (r_rnd)
            2'b00:   w_inc = r_guard & (r_sticky | r_frac[0]);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = w_inexact & ~r_sign;
            default: w_inc = w_inexact & r_sign;
        endcase
    end

    // Fraction carry-out means significand 10.000 -> 1.000 with exponent+1;
    // the low MAN_W bits are already zero in that case.
    assign w_frac_rnd = {1'b0, r_frac} + (MAN_W+1)'(w_inc);
    assign w_exp_fin  = r_exp + EW2'(w_frac_rnd[MAN_W]);
    assign w_of       = !w_exp_fin[EW2-1] && (w_exp_fin >= EMAX_E);
    assign w_uf       = w_exp_fin[EW2-1] || (w_exp_fin == '0);
    assign w_to_inf   = (r_rnd == 2'b00) || ((r_rnd == 2'b10) && !r_sign) ||
                        ((r_rnd == 2'b11) && r_sign);

    always_comb begin
        w_rnd_res = {r_sign, w_exp_fin[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
        w_rnd_fl  = {3'b000, w_inexact};
        if (w_of) begin
            w_rnd_res = {r_sign, w_to_inf ? MAG_INF : MAG_MAX};
            w_rnd_fl  = 4'b0101;
        end else if (w_uf) begin
            w_rnd_res = {r_sign, {(W-1){1'b0}}};
            w_rnd_fl  = 4'b0011;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.result    = r_result;
        bus.flags     = (r_state == S_DONE) ? r_flags : 4'b0000;
        case (r_state)
            S_IDLE:   if (bus.in_valid) w_state_next = S_UNPACK;
            // Special results skip the multiplier and commit through ROUND.
            S_UNPACK: w_state_next = w_special ? S_ROUND : S_MULT;
            S_MULT:   if (r_cnt == CNT_LAST) w_state_next = S_NORM;
            S_NORM:   w_state_next = S_ROUND;
            S_ROUND:  w_state_next = S_DONE;
            S_DONE:   if (bus.out_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rnd     <= '0;
            r_sign    <= 1'b0;
            r_special <= 1'b0;
            r_exp     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_frac    <= '0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_a   <= bus.a;
                    r_b   <= bus.b;
                    r_rnd <= bus.rnd_mode;
                end
                S_UNPACK: begin
                    r_sign    <= w_sign;
                    r_special <= w_special;
                    r_exp     <= w_exp_sum;
                    r_mcand   <= PW'({1'b1, w_a_frac});
                    r_mplier  <= {1'b1, w_b_frac};
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_flags  <= w_spec_fl;
                    end
                end
                S_MULT: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                S_NORM: begin
                    r_exp    <= r_exp + EW2'(r_acc[PW-1]);
                    r_frac   <= w_p_norm[PW-2 -: MAN_W];
                    r_guard  <= w_p_norm[MAN_W];
                    r_sticky <= |w_p_norm[MAN_W-1:0];
                end
                S_ROUND: if (!r_special) begin
                    r_result <= w_rnd_res;
                    r_flags  <= w_rnd_fl;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_iter.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_iter
// Self-checking bench for fp_mul_iter: directed cases, handshake/reset
// behaviour and randomized operands against an integer reference model,
// for the binary32 configuration and a small EXP_W=5/MAN_W=10 configuration.
// ---------------------------------------------------------------------------
module tb_fp_mul_iter;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic        sel;            // 0: binary32 instance, 1: small instance
    logic        tb_in_valid, tb_out_ready;
    logic [31:0] tb_a, tb_b;
    logic [1:0]  tb_rm;
    logic        w_in_ready, w_out_valid;
    logic [31:0] w_result;
    logic [3:0]  w_flags;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 CLK = ~CLK;

    fp_mul_iter_if #(.EXP_W(8), .MAN_W(23)) bus_l ();
    fp_mul_iter_if #(.EXP_W(5), .MAN_W(10)) bus_s ();

    fp_mul_iter #(.EXP_W(8), .MAN_W(23)) u_dut_l (.CLK(CLK), .RSTn(RSTn), .bus(bus_l.slave));
    fp_mul_iter #(.EXP_W(5), .MAN_W(10)) u_dut_s (.CLK(CLK), .RSTn(RSTn), .bus(bus_s.slave));

    assign bus_l.in_valid  = tb_in_valid & ~sel;
    assign bus_s.in_valid  = tb_in_valid & sel;
    assign bus_l.a         = tb_a;
    assign bus_l.b         = tb_b;
    assign bus_s.a         = tb_a[15:0];
    assign bus_s.b         = tb_b[15:0];
    assign bus_l.rnd_mode  = tb_rm;
    assign bus_s.rnd_mode  = tb_rm;
    assign bus_l.out_ready = tb_out_ready;
    assign bus_s.out_ready = tb_out_ready;
    assign w_in_ready  = sel ? bus_s.in_ready  : bus_l.in_ready;
    assign w_out_valid = sel ? bus_s.out_valid : bus_l.out_valid;
    assign w_result    = sel ? {16'h0, bus_s.result} : bus_l.result;
    assign w_flags     = sel ? bus_s.flags : bus_l.flags;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product of significands, then rounding decided
    // by comparing the discarded remainder against one half ulp.
    function automatic logic [35:0] ref_mul(input int ew, input int mw,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
        longint bias, emax, mask, ea, eb, fa, fb, e, shift, p, q, rem, half;
        logic s, an, bn, asn, bsn, ai, bi, az, bz, nx, up, to_inf;
        logic [31:0] sgn, qnan, inf, maxf;
        bias = (64'sd1 << (ew - 1)) - 1;
        emax = (64'sd1 << ew) - 1;
        mask = (64'sd1 << mw) - 1;
        ea = longint'(a >> mw) & emax;  eb = longint'(b >> mw) & emax;
        fa = longint'(a) & mask;        fb = longint'(b) & mask;
        s   = a[ew+mw] ^ b[ew+mw];
        sgn = 32'(longint'(s) << (ew + mw));
        qnan = 32'((emax << mw) | (64'sd1 << (mw - 1)));
        inf  = 32'(emax << mw);
        maxf = 32'(((emax - 1) << mw) | mask);
        an = (ea == emax) && (fa != 0);  bn = (eb == emax) && (fb != 0);
        asn = an && (((fa >> (mw - 1)) & 1) == 0);
        bsn = bn && (((fb >> (mw - 1)) & 1) == 0);
        ai = (ea == emax) && (fa == 0);  bi = (eb == emax) && (fb == 0);
        az = (ea == 0);                  bz = (eb == 0);
        if (an || bn)                      return {asn || bsn, 3'b000, qnan};
        if ((ai && bz) || (bi && az))      return {4'b1000, qnan};
        if (ai || bi)                      return {4'b0000, sgn | inf};
        if (az || bz)                      return {4'b0000, sgn};
        p = (fa | (64'sd1 << mw)) * (fb | (64'sd1 << mw));
        shift = (p >= (64'sd1 << (2 * mw + 1))) ? mw + 1 : mw;
        q    = p >> shift;
        rem  = p & ((64'sd1 << shift) - 1);
        half = 64'sd1 << (shift - 1);
        e    = ea + eb - bias + shift - mw;
        nx   = (rem != 0);
        case (rm)
            2'b00:   up = (rem > half) || ((rem == half) && ((q & 1) == 1));
            2'b01:   up = 1'b0;
            2'b10:   up = nx && !s;
            default: up = nx && s;
        endcase
        if (up) q = q + 1;
        if (q == (64'sd1 << (mw + 1))) begin q = q >> 1; e = e + 1; end
        if (e >= emax) begin
            to_inf = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
            return {4'b0101, sgn | (to_inf ? inf : maxf)};
        end
        if (e <= 0) return {4'b0011, sgn};
        return {3'b000, nx, sgn | 32'(e << mw) | 32'(q & mask)};
    endfunction

    function automatic logic is_special(input int ew, input int mw, input logic [31:0] v);
        longint ex;
        ex = longint'(v >> mw) & ((64'sd1 << ew) - 1);
        return (ex == 0) || (ex == (64'sd1 << ew) - 1);
    endfunction

    function automatic logic [31:0] gen_op(input int ew, input int mw);
        longint emax, bias, mask, ex, fr;
        logic sg;
        emax = (64'sd1 << ew) - 1;
        bias = (64'sd1 << (ew - 1)) - 1;
        mask = (64'sd1 << mw) - 1;
        sg = 1'($urandom_range(0, 1));
        fr = longint'($urandom) & mask;
        // Sparse fractions make exact halfway products (RNE ties) likely.
        if ($urandom_range(0, 3) == 0) fr = fr & ((64'sd7 << (mw - 3)) | 1);
        case ($urandom_range(0, 15))
            0:             ex = 0;
            1:             begin ex = emax; fr = 0; end
            2:             begin ex = emax; if (fr == 0) fr = 1; end
            3, 4, 5, 6, 7: ex = longint'($urandom_range(1, int'(emax - 1)));
            default:       ex = bias - 3 + longint'($urandom_range(0, 6));
        endcase
        return 32'((longint'(sg) << (ew + mw)) | (ex << mw) | fr);
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        int n;
        tb_a = a; tb_b = b; tb_rm = rm; tb_in_valid = 1'b1;
        n = 0;
        while (!w_in_ready && n < 100) begin @(negedge CLK); n++; end
        if (!w_in_ready) check_val("accept_timeout", 64'(w_in_ready), 64'd1);
        @(negedge CLK);
        tb_in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!w_out_valid && lat < 200) begin @(negedge CLK); lat++; end
    endtask

    task automatic finish_op();
        tb_out_ready = 1'b1;
        @(negedge CLK);
        tb_out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm, input logic [31:0] exp_res,
                          input logic [3:0] exp_fl, input int exp_lat);
        int lat;
        start_op(a, b, rm);
        wait_done(lat);
        $display("op %s: a=%h b=%h rm=%0d -> result=%h flags=%b latency=%0d",
                 tag, a, b, rm, w_result, w_flags, lat);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_res"}, 64'(w_result), 64'(exp_res));
        check_val({tag, "_flags"}, 64'(w_flags), 64'(exp_fl));
        finish_op();
        check_val({tag, "_ovalid_drop"}, 64'({w_out_valid, w_in_ready}), 64'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rm;
        logic [35:0] exp_v;
        int          lat;
        logic        seen;

        RSTn = 1'b0; sel = 1'b0; tb_in_valid = 1'b0; tb_out_ready = 1'b0;
        tb_a = '0; tb_b = '0; tb_rm = '0;
        repeat (3) @(negedge CLK);
        check_val("rst_state", 64'({w_out_valid, w_result, w_flags}), 64'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        check_val("rst_in_ready", 64'({bus_l.in_ready, bus_s.in_ready}), 64'b11);

        // Directed cases (binary32)
        run_op("mul3",      32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 27);
        run_op("nx_rne",    32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001, 27);
        run_op("nx_rup",    32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0001, 27);
        run_op("nx_rtz",    32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0001, 27);
        run_op("tie_rne",   32'h3F800001, 32'h3FC00000, 2'b00, 32'h3FC00002, 4'b0001, 27);
        run_op("tie_rtz",   32'h3F800001, 32'h3FC00000, 2'b01, 32'h3FC00001, 4'b0001, 27);
        run_op("of_rne",    32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 4'b0101, 27);
        run_op("of_rtz",    32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b0101, 27);
        run_op("of_rup_neg",32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF7FFFFF, 4'b0101, 27);
        run_op("inf_x_0",   32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b1000, 2);
        run_op("snan",      32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000, 2);
        run_op("negzero",   32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 4'b0000, 2);
        run_op("uf",        32'h80800000, 32'h3F000000, 2'b00, 32'h80000000, 4'b0011, 27);

        // Backpressure: result held, no second acceptance while DONE
        start_op(32'h3FC00000, 32'h40000000, 2'b00);
        wait_done(lat);
        tb_in_valid = 1'b1; tb_a = 32'h40000000; tb_b = 32'h40000000;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("hold%0d", i), 64'({w_out_valid, w_in_ready, w_result}),
                      64'({1'b1, 1'b0, 32'h40400000}));
            @(negedge CLK);
        end
        tb_in_valid = 1'b0;
        finish_op();
        check_val("hold_release", 64'({w_out_valid, w_in_ready}), 64'b01);
        seen = 1'b0;
        repeat (30) begin @(negedge CLK); seen = seen | w_out_valid; end
        check_val("hold_no_second_op", 64'(seen), 64'd0);

        // Reset during MULT aborts the operation
        start_op(32'h3FC00000, 32'h40000000, 2'b00);
        repeat (5) @(negedge CLK);
        check_val("busy_in_ready", 64'(w_in_ready), 64'd0);
        #2 RSTn = 1'b0;
        #1 check_val("rst_mult_async", 64'({w_out_valid, w_in_ready}), 64'b01);
        @(negedge CLK);
        RSTn = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge CLK); seen = seen | w_out_valid; end
        check_val("rst_abort", 64'(seen), 64'd0);
        run_op("after_rst", 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 27);

        // Reset while a result is presented clears outputs at once
        start_op(32'h3F800001, 32'h3F800001, 2'b10);
        wait_done(lat);
        check_val("pre_rst_valid", 64'(w_out_valid), 64'd1);
        #2 RSTn = 1'b0;
        #1 check_val("rst_done_async", 64'({w_out_valid, w_result, w_flags}), 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        // Randomized binary32
        for (int i = 0; i < 150; i++) begin
            ra = gen_op(8, 23); rb = gen_op(8, 23); rm = 2'($urandom_range(0, 3));
            exp_v = ref_mul(8, 23, ra, rb, rm);
            run_op($sformatf("r32_%0d", i), ra, rb, rm, exp_v[31:0], exp_v[35:32],
                   (is_special(8, 23, ra) || is_special(8, 23, rb)) ? 2 : 27);
        end

        // Small configuration
        sel = 1'b1;
        @(negedge CLK);
        run_op("small_mul3", 32'h3E00, 32'h4000, 2'b00, 32'h4200, 4'b0000, 14);
        for (int i = 0; i < 60; i++) begin
            ra = gen_op(5, 10); rb = gen_op(5, 10); rm = 2'($urandom_range(0, 3));
            exp_v = ref_mul(5, 10, ra, rb, rm);
            run_op($sformatf("r16_%0d", i), ra, rb, rm, exp_v[31:0], exp_v[35:32],
                   (is_special(5, 10, ra) || is_special(5, 10, rb)) ? 2 : 14);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
